multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; legal values are 8 to 64.
REQ-002 The block SHALL have derived constant SHW = clog2(WIDTH), the shift-amount width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to perform op on src_a/src_b.
REQ-006 The block SHALL have port op, input, 5 bits: operation code, decoded per the shared package.
REQ-007 The block SHALL have ports src_a and src_b, inputs, WIDTH bits each: operands.
REQ-008 The block SHALL have port busy, output, 1 bit: an iterative multiply/divide is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that the outputs are valid.
REQ-010 The block SHALL have port result, output, WIDTH bits: single-cycle result, or LO for multiply/divide.
REQ-011 The block SHALL have port hi, output, WIDTH bits: multiply upper half, or divide remainder.
REQ-012 The block SHALL have ports zero, overflow and divzero, outputs, 1 bit each: registered status flags.

Function
REQ-013 The block SHALL support these ops: AND, OR, XOR, NOR, ADD, SUB, ADDO, SUBO, SLT, SLTU, SLLV, SRLV, SRAV, MULT, MULTU, DIV, DIVU.
REQ-014 start SHALL be accepted only when the FSM is in IDLE; start while busy SHALL be ignored with no effect on state or outputs.
REQ-015 The FSM SHALL have two states, IDLE and ITER: IDLE->ITER on an accepted MULT/MULTU/DIV/DIVU; ITER->IDLE when the iteration count reaches WIDTH; all other transitions stay.
REQ-016 A single-cycle op accepted at edge N SHALL drive result, zero, overflow and done=1 after edge N, i.e. latency 1.
REQ-017 A multiply/divide accepted at edge N SHALL hold busy=1 for exactly WIDTH cycles, after edges N..N+WIDTH-1.
REQ-018 A multiply/divide accepted at edge N SHALL update result, hi and flags and assert done=1 after edge N+WIDTH, the same edge busy falls.
REQ-019 done SHALL be high for exactly one cycle per accepted op.
REQ-020 result, hi and the flags SHALL hold their values until the next done.
REQ-021 For ops that do not define hi, hi SHALL hold its previous value.
REQ-022 Shift ops SHALL shift src_b by src_a[SHW-1:0]; SRAV SHALL fill with src_b[WIDTH-1].
REQ-023 SLT SHALL compare two's complement values and SLTU unsigned values; the result SHALL be 1 or 0, zero-extended.
REQ-024 ADDO/SUBO SHALL set overflow=1 when the operand signs (for SUBO: src_a and the negated src_b) match and the result sign differs; the wrapped result SHALL still be written.
REQ-025 All ops other than ADDO/SUBO SHALL write overflow=0.
REQ-026 zero SHALL equal (result == 0) for the completing op.
REQ-027 MULT/MULTU SHALL produce the full 2*WIDTH product, {hi, result}, signed or unsigned, via shift-add with one bit per cycle.
REQ-028 DIV/DIVU SHALL use restoring division with one quotient bit per cycle: quotient to result, remainder to hi.
REQ-029 Signed DIV SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend.
REQ-030 A divisor of 0 SHALL give divzero=1, result = all ones, hi = src_a, and the full WIDTH-cycle latency.
REQ-031 DIV of the most negative value by -1 SHALL give result = most negative value, hi=0, overflow=1.
REQ-032 Operands SHALL be captured at acceptance; later changes to src_a/src_b/op SHALL NOT affect the op in flight.
REQ-033 An undefined op SHALL complete in 1 cycle with result=0 and all flags 0.

Reset
REQ-034 reset=1 at an edge SHALL force IDLE, busy=0, done=0, result=0, hi=0, zero=0, overflow=0, divzero=0, and iteration count=0.
REQ-035 reset SHALL abort any in-flight multiply/divide with no done pulse; start sampled in the same cycle as reset SHALL be ignored.

Structure
REQ-036 Package alu_pkg SHALL hold the op-code constants, the FSM state type and the op-class helper (single-cycle vs iterative).
REQ-037 The multiply/divide datapath SHALL be a sub-module, alu_muldiv_seq, with a load/step/done interface; all combinational ops SHALL stay in the top level.

Verification
REQ-038 With WIDTH=32, ADDO of 0x7FFFFFFF and 0x00000001 SHALL give result=0x80000000, overflow=1, done one cycle after start.
REQ-039 SRAV with a=4 and b=0x80000000 SHALL give 0xF8000000; SLTU with a=1 and b=0xFFFFFFFF SHALL give 1; SLT with the same operands SHALL give 0.
REQ-040 MULT of -3 and 5 SHALL give hi=0xFFFFFFFF and result=0xFFFFFFF1, with busy high for 32 cycles and done after edge N+32.
REQ-041 DIV of 7 by -2 SHALL give result=0xFFFFFFFD and hi=1; DIVU of 9 by 0 SHALL give result=0xFFFFFFFF, hi=9, divzero=1.
REQ-042 reset asserted on the 10th cycle of a DIV SHALL give busy=0 next cycle, no done pulse, and all outputs 0; a following start SHALL be accepted normally.
REQ-043 start held high for 40 cycles during MULTU SHALL produce exactly one done, and a second op SHALL be accepted only on the first edge after done.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multicycle ALU.
//   - 5-bit operation codes (anything not listed is an undefined op)
//   - FSM state type for the top-level controller
//   - op-class helpers: iterative vs single-cycle, divide vs multiply, signedness
package alu_pkg;

  localparam int OP_W = 5;

  localparam logic [OP_W-1:0] OP_AND   = 5'd0;
  localparam logic [OP_W-1:0] OP_OR    = 5'd1;
  localparam logic [OP_W-1:0] OP_XOR   = 5'd2;
  localparam logic [OP_W-1:0] OP_NOR   = 5'd3;
  localparam logic [OP_W-1:0] OP_ADD   = 5'd4;
  localparam logic [OP_W-1:0] OP_SUB   = 5'd5;
  localparam logic [OP_W-1:0] OP_ADDO  = 5'd6;
  localparam logic [OP_W-1:0] OP_SUBO  = 5'd7;
  localparam logic [OP_W-1:0] OP_SLT   = 5'd8;
  localparam logic [OP_W-1:0] OP_SLTU  = 5'd9;
  localparam logic [OP_W-1:0] OP_SLLV  = 5'd10;
  localparam logic [OP_W-1:0] OP_SRLV  = 5'd11;
  localparam logic [OP_W-1:0] OP_SRAV  = 5'd12;
  localparam logic [OP_W-1:0] OP_MULT  = 5'd16;
  localparam logic [OP_W-1:0] OP_MULTU = 5'd17;
  localparam logic [OP_W-1:0] OP_DIV   = 5'd18;
  localparam logic [OP_W-1:0] OP_DIVU  = 5'd19;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ITER = 1'b1
  } aluState_e;

  // Multiply/divide run through the shift-add / restoring datapath.
  function automatic logic isIterOp(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic isDivOp(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic isSignedIterOp(input logic [OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: iterative multiply / divide datapath, one bit per step.
// Signed operations run on operand magnitudes; the signs are reapplied to the
// final values, so the core is a plain unsigned shift-add / restoring divider.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   load              capture operands and start a new operation
//   step              advance one iteration
//   isDiv, isSigned   operation class sampled on load
//   opA, opB          operands sampled on load (opA = multiplicand / dividend)
//   done              high during the step that completes the last iteration
//   resLo, resHi      final LO/HI values including this cycle's step (valid with done)
//   divZero, divOvf   divide-by-zero and most-negative / -1 indications
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             isDiv,
  input  logic             isSigned,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             done,
  output logic [WIDTH-1:0] resLo,
  output logic [WIDTH-1:0] resHi,
  output logic             divZero,
  output logic             divOvf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Multiply: accHi = running upper half, accLo = multiplier shifting out / product LO shifting in.
  // Divide:   accHi = partial remainder,   accLo = dividend shifting out / quotient shifting in.
  logic [WIDTH-1:0] accHiReg, accLoReg;
  logic [WIDTH-1:0] operandReg;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0] savedAReg;       // raw dividend, reported as remainder on divide by zero
  logic             isDivReg;
  logic             negLoReg;        // product or quotient must be negated
  logic             negHiReg;        // remainder must be negated (dividend was negative)
  logic             divZeroReg, divOvfReg;
  logic [CW-1:0]    countReg;

  logic [WIDTH-1:0] absA, absB;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic [WIDTH-1:0] divSub;
  logic             divGeq;
  logic [WIDTH-1:0] stepHi, stepLo;
  logic [2*WIDTH-1:0] prodRaw, prodFix;

  always_comb begin
    absA = (isSigned && opA[WIDTH-1]) ? -opA : opA;
    absB = (isSigned && opB[WIDTH-1]) ? -opB : opB;
  end

  always_comb begin
    mulSum   = {1'b0, accHiReg} + (accLoReg[0] ? {1'b0, operandReg} : '0);
    divShift = {accHiReg, accLoReg[WIDTH-1]};
    divGeq   = (divShift >= {1'b0, operandReg});
    // When divGeq holds the true difference is below 2**WIDTH, so a WIDTH-bit subtract is exact.
    divSub   = divShift[WIDTH-1:0] - operandReg;
    stepHi   = mulSum[WIDTH:1];
    stepLo   = {mulSum[0], accLoReg[WIDTH-1:1]};
    if (isDivReg) begin
      stepHi = divGeq ? divSub : divShift[WIDTH-1:0];
      stepLo = {accLoReg[WIDTH-2:0], divGeq};
    end
  end

  // Final values are formed from the post-step state so the top can capture
  // them on the same edge as the last iteration.
  always_comb begin
    prodRaw = {stepHi, stepLo};
    prodFix = negLoReg ? -prodRaw : prodRaw;
    resLo   = prodFix[WIDTH-1:0];
    resHi   = prodFix[2*WIDTH-1:WIDTH];
    if (isDivReg) begin
      if (divZeroReg) begin
        resLo = '1;
        resHi = savedAReg;
      end else begin
        resLo = negLoReg ? -stepLo : stepLo;
        resHi = negHiReg ? -stepHi : stepHi;
      end
    end
  end

  assign done    = step && (countReg == LAST_COUNT);
  assign divZero = divZeroReg;
  assign divOvf  = divOvfReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      accHiReg   <= '0;
      accLoReg   <= '0;
      operandReg <= '0;
      savedAReg  <= '0;
      isDivReg   <= 1'b0;
      negLoReg   <= 1'b0;
      negHiReg   <= 1'b0;
      divZeroReg <= 1'b0;
      divOvfReg  <= 1'b0;
      countReg   <= '0;
    end else if (load) begin
      accHiReg   <= '0;
      accLoReg   <= isDiv ? absA : absB;
      operandReg <= isDiv ? absB : absA;
      savedAReg  <= opA;
      isDivReg   <= isDiv;
      negLoReg   <= isSigned && (opA[WIDTH-1] ^ opB[WIDTH-1]);
      negHiReg   <= isSigned && opA[WIDTH-1];
      divZeroReg <= isDiv && (opB == '0);
      divOvfReg  <= isDiv && isSigned && (opA == MOST_NEG) && (opB == '1);
      countReg   <= '0;
    end else if (step) begin
      accHiReg <= stepHi;
      accLoReg <= stepLo;
      countReg <= done ? '0 : countReg + CW'(1);
    end
  end

endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu: ALU with single-cycle logic/arith/shift/compare ops and
// iterative (WIDTH-cycle) multiply and divide.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, op             request an operation (accepted only while idle)
//   src_a, src_b          operands, captured on acceptance
//   busy                  iterative op in progress
//   done                  one-cycle pulse: result/hi/flags just updated
//   result, hi            LO/quotient or single-cycle result; HI/remainder
//   zero, overflow, divzero  registered status of the completing op
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             overflow,
  output logic             divzero
);

  localparam int SHW = $clog2(WIDTH);

  aluState_e stateReg, stateNext;
  logic accept, seqLoad, seqStep;
  logic seqDone, seqDivZero, seqOvf;
  logic [WIDTH-1:0] seqLo, seqHi;

  logic [WIDTH-1:0] resultReg, hiReg;
  logic doneReg, zeroReg, overflowReg, divzeroReg;

  logic [WIDTH-1:0] sumAB, diffAB, scResult;
  logic [SHW-1:0]   shAmt;
  logic             scOvf;

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (reset) stateReg <= IDLE;
    else       stateReg <= stateNext;
  end

  // ---- FSM: next state ----
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (start && isIterOp(op)) stateNext = ITER;
      ITER:    if (seqDone) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    busy    = (stateReg == ITER);
    accept  = (stateReg == IDLE) && start;
    seqLoad = accept && isIterOp(op);
    seqStep = (stateReg == ITER);
  end

  alu_muldiv_seq #(.WIDTH(WIDTH)) uMulDiv (
    .clk      (clk),
    .reset    (reset),
    .load     (seqLoad),
    .step     (seqStep),
    .isDiv    (isDivOp(op)),
    .isSigned (isSignedIterOp(op)),
    .opA      (src_a),
    .opB      (src_b),
    .done     (seqDone),
    .resLo    (seqLo),
    .resHi    (seqHi),
    .divZero  (seqDivZero),
    .divOvf   (seqOvf)
  );

  // ---- single-cycle datapath ----
  always_comb begin
    sumAB    = src_a + src_b;
    diffAB   = src_a - src_b;
    shAmt    = src_a[SHW-1:0];
    scResult = '0;
    scOvf    = 1'b0;
    case (op)
      OP_AND:  scResult = src_a & src_b;
      OP_OR:   scResult = src_a | src_b;
      OP_XOR:  scResult = src_a ^ src_b;
      OP_NOR:  scResult = ~(src_a | src_b);
      OP_ADD:  scResult = sumAB;
      OP_SUB:  scResult = diffAB;
      OP_ADDO: begin
        scResult = sumAB;
        scOvf    = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sumAB[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_SUBO: begin
        // Subtracting flips the effective sign of src_b.
        scResult = diffAB;
        scOvf    = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diffAB[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_SLT:  scResult = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: scResult = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      OP_SLLV: scResult = src_b << shAmt;
      OP_SRLV: scResult = src_b >> shAmt;
      OP_SRAV: scResult = $signed(src_b) >>> shAmt;
      default: scResult = '0;   // undefined ops (and iterative ops, which never use this path)
    endcase
  end

  // ---- result / flag registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      resultReg   <= '0;
      hiReg       <= '0;
      doneReg     <= 1'b0;
      zeroReg     <= 1'b0;
      overflowReg <= 1'b0;
      divzeroReg  <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      if (accept && !isIterOp(op)) begin
        resultReg   <= scResult;
        zeroReg     <= (scResult == '0);
        overflowReg <= scOvf;
        divzeroReg  <= 1'b0;
        doneReg     <= 1'b1;
      end else if (seqDone) begin
        resultReg   <= seqLo;
        hiReg       <= seqHi;
        zeroReg     <= (seqLo == '0);
        overflowReg <= seqOvf;
        divzeroReg  <= seqDivZero;
        doneReg     <= 1'b1;
      end
    end
  end

  assign done     = doneReg;
  assign result   = resultReg;
  assign hi       = hiReg;
  assign zero     = zeroReg;
  assign overflow = overflowReg;
  assign divzero  = divzeroReg;

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [4:0]   op;
  logic [W-1:0] src_a, src_b;
  logic         busy, done, zero, overflow, divzero;
  logic [W-1:0] result, hi;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .hi       (hi),
    .zero     (zero),
    .overflow (overflow),
    .divzero  (divzero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkW(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic runSingle(input string tag, input logic [4:0] opc,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] expRes, input logic expZero, input logic expOvf);
    start = 1'b1; op = opc; src_a = a; src_b = b;
    tick();
    start = 1'b0;
    check1({tag, ".done"}, done, 1'b1);
    check1({tag, ".busy"}, busy, 1'b0);
    checkW({tag, ".result"}, result, expRes);
    check1({tag, ".zero"}, zero, expZero);
    check1({tag, ".overflow"}, overflow, expOvf);
    check1({tag, ".divzero"}, divzero, 1'b0);
    $display("txn %s op=%0d a=%h b=%h result=%h ovf=%b", tag, opc, a, b, result, overflow);
  endtask

  task automatic runIter(input string tag, input logic [4:0] opc,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] expRes, input logic [W-1:0] expHi,
                         input logic expOvf, input logic expDz);
    int cycles;
    logic earlyDone;
    start = 1'b1; op = opc; src_a = a; src_b = b;
    tick();
    start = 1'b0;
    // Operands must have been captured; scramble the inputs while in flight.
    src_a = $urandom; src_b = $urandom; op = 5'($urandom);
    cycles = 0;
    earlyDone = 1'b0;
    while (busy && cycles < 100) begin
      cycles++;
      if (done) earlyDone = 1'b1;
      tick();
    end
    checkInt({tag, ".busyCycles"}, cycles, W);
    check1({tag, ".earlyDone"}, earlyDone, 1'b0);
    check1({tag, ".done"}, done, 1'b1);
    checkW({tag, ".result"}, result, expRes);
    checkW({tag, ".hi"}, hi, expHi);
    check1({tag, ".overflow"}, overflow, expOvf);
    check1({tag, ".divzero"}, divzero, expDz);
    check1({tag, ".zero"}, zero, (expRes == '0));
    $display("txn %s op=%0d a=%h b=%h hi=%h result=%h cycles=%0d", tag, opc, a, b, hi, result, cycles);
    tick();
    check1({tag, ".donePulse"}, done, 1'b0);
  endtask

  initial begin
    int doneCount;
    int doneIdx;
    int n;
    logic busyAt33;
    logic [W-1:0] resAtDone, hiAtDone;

    reset = 1'b1; start = 1'b0; op = OP_AND; src_a = '0; src_b = '0;
    tick(); tick();
    check1("reset.busy", busy, 1'b0);
    check1("reset.done", done, 1'b0);
    checkW("reset.result", result, '0);
    checkW("reset.hi", hi, '0);
    check1("reset.zero", zero, 1'b0);
    check1("reset.overflow", overflow, 1'b0);
    check1("reset.divzero", divzero, 1'b0);
    reset = 1'b0;
    tick();

    // Single-cycle ops
    runSingle("addo_ovf", OP_ADDO, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
    tick();
    check1("addo_ovf.donePulse", done, 1'b0);
    checkW("addo_ovf.hold", result, 32'h8000_0000);
    runSingle("srav", OP_SRAV, 32'd4, 32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0);
    runSingle("sltu", OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    runSingle("slt", OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
    runSingle("subo_ovf", OP_SUBO, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    runSingle("sub_noovf", OP_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b0);
    runSingle("and", OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0);
    runSingle("or", OP_OR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0);
    runSingle("xor_self", OP_XOR, 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b1, 1'b0);
    runSingle("nor", OP_NOR, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    runSingle("sllv", OP_SLLV, 32'd36, 32'd1, 32'h0000_0010, 1'b0, 1'b0);
    runSingle("srlv", OP_SRLV, 32'd4, 32'h8000_0000, 32'h0800_0000, 1'b0, 1'b0);
    runSingle("subo_pre", OP_SUBO, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    runSingle("undef", 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);

    // Iterative ops
    runIter("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    runSingle("add_hihold", OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0);
    checkW("add_hihold.hi", hi, 32'hFFFF_FFFF);
    runIter("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0);
    runIter("multu_zero", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0000_0001, 1'b0, 1'b0);
    runIter("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
    runIter("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    runIter("divu_by0", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1'b0, 1'b1);
    runIter("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b1, 1'b0);
    runIter("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);

    // Reset during the 10th busy cycle of a DIV; start in the same cycle is ignored.
    start = 1'b1; op = OP_DIV; src_a = 32'd1000; src_b = 32'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check1("abort.busyBefore", busy, 1'b1);
    reset = 1'b1; start = 1'b1; op = OP_ADD; src_a = 32'd1; src_b = 32'd1;
    tick();
    reset = 1'b0; start = 1'b0;
    check1("abort.busy", busy, 1'b0);
    check1("abort.done", done, 1'b0);
    checkW("abort.result", result, '0);
    checkW("abort.hi", hi, '0);
    check1("abort.zero", zero, 1'b0);
    check1("abort.overflow", overflow, 1'b0);
    check1("abort.divzero", divzero, 1'b0);
    doneCount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) doneCount++;
    end
    checkInt("abort.noActivity", doneCount, 0);
    $display("txn abort_reset busy=%b done=%b result=%h hi=%h", busy, done, result, hi);
    runIter("after_abort", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);

    // start held high for 40 cycles during MULTU
    start = 1'b1; op = OP_MULTU; src_a = 32'd6; src_b = 32'd7;
    doneCount = 0; doneIdx = -1; busyAt33 = 1'b0; resAtDone = '0; hiAtDone = '1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) begin
        doneCount++;
        if (doneIdx < 0) begin
          doneIdx = i;
          resAtDone = result;
          hiAtDone = hi;
        end
      end
      if (i == 33) busyAt33 = busy;
    end
    start = 1'b0;
    checkInt("held.doneCount", doneCount, 1);
    checkInt("held.doneIdx", doneIdx, W);
    checkW("held.result", resAtDone, 32'd42);
    checkW("held.hi", hiAtDone, 32'd0);
    check1("held.reaccept", busyAt33, 1'b1);
    n = 0;
    while (!done && n < 60) begin
      tick();
      n++;
    end
    check1("held.secondDone", done, 1'b1);
    checkW("held.secondResult", result, 32'd42);
    $display("txn multu_held doneIdx=%0d result=%h second_wait=%0d", doneIdx, resAtDone, n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
